dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the byte-addressed data memory between two requesters: port 0 (core load/store unit) and port 1 (debug/loader).
- Round-robin arbitration, one transaction in flight.
- Converts byte/halfword stores into read-modify-write, since the memory only writes whole words.
- Extracts and extends sub-word load data.
- Sits between the core datapath and the data memory.

Parameters:
- DEPTH_BYTES, 1024, memory size in bytes; addresses with addr > DEPTH_BYTES-4 are out of range.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- m0_req  in  1  port 0 request; held high until m0_ready
- m0_we  in  1  1=store, 0=load
- m0_size  in  2  00=byte, 01=half, 10=word, 11=reserved (error)
- m0_unsigned  in  1  load zero-extend when 1, sign-extend when 0
- m0_addr  in  ADDR_W  byte address
- m0_wdata  in  32  store data, lane-0 justified for sub-word
- m0_gnt  out  1  request accepted this cycle
- m0_ready  out  1  one-cycle completion pulse
- m0_err  out  1  valid with m0_ready; bad size/range/alignment
- m0_rdata  out  32  load result, valid with m0_ready
- m1_*  same set as m0_* for port 1
- mem_ce  out  1  memory chip enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  write word, byte 0 at bits 7:0
- mem_rdata  in  32  combinational read data of mem_addr

Behaviour:
- States: IDLE, RD, WR, DONE.
- IDLE:
  - If any req is high, grant one port. On a tie, grant the port not granted last; the last-grant register resets to 1, so port 0 wins the first tie.
  - Assert gnt combinationally in that cycle.
  - Latch we, size, unsigned, addr and wdata.
  - Next state:
    - Error request -> DONE with err.
    - Load or sub-word store -> RD.
    - Word store -> WR.
- RD:
  - mem_ce=1, mem_we=0.
  - Capture mem_rdata into the word buffer.
  - Load -> DONE. Sub-word store -> WR.
- WR:
  - mem_ce=1, mem_we=1.
  - mem_wdata is either wdata (word store) or the buffer with the addressed byte/half lane replaced by wdata[7:0]/[15:0] (lane = addr[1:0]).
  - Next state: DONE.
- DONE:
  - Granted port's ready=1 for exactly one cycle, with err and rdata; next state IDLE.
  - Load rdata: byte lane addr[1:0] or half lane addr[1], extended per unsigned; word passes through.
  - Store rdata = 0.
- Latency, with accept at edge N:
  - Word load / word store: ready in cycle N+2.
  - Sub-word store: ready in cycle N+3.
  - Error: ready in cycle N+1.
  - Peak throughput: one word access per 3 cycles.
- The non-granted port sees gnt=0 and ready=0; its req stays pending with no loss.
- Error conditions: size=11 or out of range. Errors never assert mem_ce.
- mem_ce and mem_we are 0 in IDLE and DONE, and are gated with !rst.
- Reset:
  - State -> IDLE; all gnt/ready/err = 0; rdata = 0; buffer = 0; last-grant = 1.
  - Reset asserted mid-transaction aborts it. No write occurs in any cycle with rst=1, and no ready is issued for the aborted transaction.
- req dropping before ready is illegal; the transaction still completes.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, is an error: no memory access, ready+err in N+1.
- Undefined:
  - Low address bits ignored for half (addr[0]) and word (addr[1:0]); access proceeds on the aligned lane.
  - err is asserted only for size=11 or out of range.

Test Plan:
- Memory word 0x10 = 0x8899AABB; m0 byte load at 0x12, unsigned=0 -> m0_gnt at N, one RD cycle, m0_ready at N+2, m0_rdata=0xFFFFFF99; repeat with unsigned=1 -> 0x00000099.
- m0 half store 0x1234 at 0x12 over 0x8899AABB -> RD then WR with mem_wdata=0x1234AABB, ready at N+3; a word load of 0x10 then returns 0x1234AABB.
- m0 and m1 both request loads continuously from reset -> grants alternate m0, m1, m0, m1; each port gets one ready per 6 cycles.
- m1 word store 0xDEADBEEF at 0x0C -> mem_we high exactly one cycle with mem_addr=0x0C; a subsequent m0 load of 0x0C returns 0xDEADBEEF.
- Error cases, mem_ce never asserted:
  - m0 word load at DEPTH_BYTES -> m0_err=1 with ready at N+1.
  - With DMEM_MISALIGN_CHECK_EN, half load at 0x11 -> err=1 with ready at N+1.
  - Without the macro, half load at 0x11 -> data of lane 0x10 returned, err=0.
- rst asserted during the RD cycle of a sub-word store -> no write cycle occurs, no ready issued, memory word unchanged; next request is serviced normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a word-wide data memory between two requesters
// (port 0 = core load/store unit, port 1 = debug/loader).
// Round-robin grant, one transaction in flight. Sub-word stores become
// read-modify-write; sub-word loads are lane-extracted and extended.
// Optional build macro: DMEM_MISALIGN_CHECK_EN -- when defined, a half
// access with addr[0]=1 or a word access with addr[1:0]!=0 is an error.
// When undefined, the low address bits are ignored for half/word accesses.
//
// Handshake: a requester raises mN_req with we/size/unsigned/addr/wdata
// stable and holds them until mN_ready. mN_gnt is high (combinationally)
// in the cycle the request is accepted; the fields are latched at the end
// of that cycle. mN_ready pulses for exactly one cycle when mN_err and
// mN_rdata are valid. The other port sees gnt=0/ready=0 and stays pending.
module dmem_arbiter #(
   parameter int DEPTH_BYTES = 1024,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   // port 0
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [1:0]        m0_size,
   input  logic              m0_unsigned,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   output logic              m0_gnt,
   output logic              m0_ready,
   output logic              m0_err,
   output logic [31:0]       m0_rdata,
   // port 1
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [1:0]        m1_size,
   input  logic              m1_unsigned,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   output logic              m1_gnt,
   output logic              m1_ready,
   output logic              m1_err,
   output logic [31:0]       m1_rdata,
   // memory
   output logic              mem_ce,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   // Highest legal byte address (a full word must fit below DEPTH_BYTES).
   localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH_BYTES - 4);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic              last_q, last_d;     // most recent grant; owns the in-flight transaction
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       buf_q, buf_d;       // word read during RD
   logic              err_q, err_d;

   logic              any_req;
   logic              sel;
   logic              grant;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_uns;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              req_err;
   logic              misalign;
   logic              ce_raw;
   logic              we_raw;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [31:0]       load_word;
   logic [31:0]       wr_word;
   logic [31:0]       rsp_data;
   logic              done;

   // Round-robin selection and mux of the selected requester's command.
   always_comb begin
      any_req = m0_req | m1_req;
      if (m0_req && m1_req) begin
         sel = ~last_q;
      end else begin
         sel = m1_req;
      end
      grant     = (state_q == ST_IDLE) && any_req && !rst;
      req_we    = sel ? m1_we       : m0_we;
      req_size  = sel ? m1_size     : m0_size;
      req_uns   = sel ? m1_unsigned : m0_unsigned;
      req_addr  = sel ? m1_addr     : m0_addr;
      req_wdata = sel ? m1_wdata    : m0_wdata;
   end

   // Classify the selected request as an error before any memory access.
   always_comb begin
`ifdef DMEM_MISALIGN_CHECK_EN
      misalign = ((req_size == 2'b01) && req_addr[0]) ||
                 ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      req_err = (req_size == 2'b11) || (req_addr > MAX_ADDR) || misalign;
   end

   // Next-state logic and command latching.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      buf_d   = buf_q;
      err_d   = err_q;
      ce_raw  = 1'b0;
      we_raw  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               last_d  = sel;
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_uns;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               err_d   = req_err;
               if (req_err) begin
                  state_d = ST_DONE;
               end else if (req_we && (req_size == 2'b10)) begin
                  state_d = ST_WR;
               end else begin
                  state_d = ST_RD;
               end
            end
         end
         ST_RD: begin
            ce_raw  = 1'b1;
            buf_d   = mem_rdata;
            state_d = we_q ? ST_WR : ST_DONE;
         end
         ST_WR: begin
            ce_raw  = 1'b1;
            we_raw  = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sub-word load extraction and sign/zero extension from the word buffer.
   always_comb begin
      ld_byte = 8'h00;
      case (addr_q[1:0])
         2'd0: ld_byte = buf_q[7:0];
         2'd1: ld_byte = buf_q[15:8];
         2'd2: ld_byte = buf_q[23:16];
         2'd3: ld_byte = buf_q[31:24];
         default: ld_byte = 8'h00;
      endcase
      ld_half = addr_q[1] ? buf_q[31:16] : buf_q[15:0];
      case (size_q)
         2'b00:   load_word = {{24{~uns_q & ld_byte[7]}}, ld_byte};
         2'b01:   load_word = {{16{~uns_q & ld_half[15]}}, ld_half};
         default: load_word = buf_q;
      endcase
   end

   // Write word: whole wdata for word stores, else merge into the read word.
   always_comb begin
      wr_word = buf_q;
      case (size_q)
         2'b00: begin
            case (addr_q[1:0])
               2'd0: wr_word[7:0]   = wdata_q[7:0];
               2'd1: wr_word[15:8]  = wdata_q[7:0];
               2'd2: wr_word[23:16] = wdata_q[7:0];
               2'd3: wr_word[31:24] = wdata_q[7:0];
               default: wr_word = buf_q;
            endcase
         end
         2'b01: begin
            if (addr_q[1]) begin
               wr_word[31:16] = wdata_q[15:0];
            end else begin
               wr_word[15:0] = wdata_q[15:0];
            end
         end
         default: wr_word = wdata_q;
      endcase
   end

   // Port and memory outputs; memory strobes are suppressed while in reset.
   always_comb begin
      done      = (state_q == ST_DONE);
      rsp_data  = (we_q || err_q) ? 32'h0 : load_word;
      m0_gnt    = grant && !sel;
      m1_gnt    = grant && sel;
      m0_ready  = done && !last_q && !rst;
      m1_ready  = done && last_q && !rst;
      m0_err    = m0_ready && err_q;
      m1_err    = m1_ready && err_q;
      m0_rdata  = m0_ready ? rsp_data : 32'h0;
      m1_rdata  = m1_ready ? rsp_data : 32'h0;
      mem_ce    = ce_raw && !rst;
      mem_we    = we_raw && !rst;
      mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
      mem_wdata = wr_word;
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         buf_q   <= 32'h0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         buf_q   <= buf_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural byte-array memory model, two port
// drivers, expected-response queue, bounded waits and a one-line report.
`timescale 1ns/1ps
module tb_dmem_arbiter;

   localparam int DEPTH_BYTES = 1024;
   localparam int ADDR_W      = 32;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        m0_req = 0, m0_we = 0, m0_unsigned = 0;
   logic [1:0]  m0_size = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0;
   logic        m0_gnt, m0_ready, m0_err;
   logic [31:0] m0_rdata;
   logic        m1_req = 0, m1_we = 0, m1_unsigned = 0;
   logic [1:0]  m1_size = 0;
   logic [31:0] m1_addr = 0, m1_wdata = 0;
   logic        m1_gnt, m1_ready, m1_err;
   logic [31:0] m1_rdata;
   logic        mem_ce, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   // memory seen by the DUT
   logic [31:0] mem_arr [0:255];
   logic        pre_en = 0;
   logic [7:0]  pre_idx = 0;
   logic [31:0] pre_val = 0;
   // reference model memory, byte granular
   logic [7:0]  ref_mem [0:DEPTH_BYTES-1];

   int          cyc = 0, ce_cnt = 0, wr_cnt = 0;
   logic [31:0] last_waddr = 0, last_wdata = 0;
   int          n_checks = 0, n_fail = 0;
   logic [32:0] exp_q[$];
   txn_t        q0[$], q1[$];
   int          gnt_order[$];
   logic [31:0] last_rdata [2];
   logic        last_err [2];

   dmem_arbiter #(.DEPTH_BYTES(DEPTH_BYTES), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_unsigned(m0_unsigned),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_ready(m0_ready),
      .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_unsigned(m1_unsigned),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_ready(m1_ready),
      .m1_err(m1_err), .m1_rdata(m1_rdata),
      .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // clock / memory block
   always #5 clk = ~clk;

   assign mem_rdata = mem_arr[mem_addr[9:2]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_ce) ce_cnt <= ce_cnt + 1;
      if (mem_ce && mem_we) begin
         mem_arr[mem_addr[9:2]] <= mem_wdata;
         wr_cnt     <= wr_cnt + 1;
         last_waddr <= mem_addr;
         last_wdata <= mem_wdata;
      end else if (pre_en) begin
         mem_arr[pre_idx] <= pre_val;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h expected=0x%08h t=%0t", tag, got, exp, $time);
      end
   endtask

   // continuous monitors: no memory strobe in reset, grants exclusive
   always @(negedge clk) begin
      #2;
      if (rst) check("ce_in_rst", {31'b0, mem_ce}, 32'h0);
      if (m0_gnt || m1_gnt) check("gnt_onehot", {31'b0, m0_gnt & m1_gnt}, 32'h0);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog t=%0t", $time);
      $fatal(1, "watchdog expired");
   end

   // reference model: executes one transaction on the byte array
   function automatic logic [32:0] model_exec(input txn_t t);
      int          nb, base;
      logic [31:0] v;
      bit          err;
      err = (t.size == 2'b11) || (t.addr > 32'(DEPTH_BYTES - 4));
`ifdef DMEM_MISALIGN_CHECK_EN
      if (t.size == 2'b01 && t.addr[0]) err = 1;
      if (t.size == 2'b10 && t.addr[1:0] != 2'b00) err = 1;
`endif
      if (err) return {1'b1, 32'h0};
      nb   = 1 << t.size;
      base = int'(t.addr) - (int'(t.addr) % nb);
      if (t.we) begin
         for (int i = 0; i < nb; i++) ref_mem[base + i] = t.wdata[8*i +: 8];
         return 33'h0;
      end
      v = 32'h0;
      for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
      if (nb < 4 && !t.uns && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      return {1'b0, v};
   endfunction

   task automatic preload(input int idx, input logic [31:0] w);
      pre_en  = 1'b1;
      pre_idx = idx[7:0];
      pre_val = w;
      for (int b = 0; b < 4; b++) ref_mem[idx*4 + b] = w[8*b +: 8];
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   task automatic set_port(input int p, input logic req, input txn_t t);
      if (p == 0) begin
         m0_req = req; m0_we = t.we; m0_size = t.size; m0_unsigned = t.uns;
         m0_addr = t.addr; m0_wdata = t.wdata;
      end else begin
         m1_req = req; m1_we = t.we; m1_size = t.size; m1_unsigned = t.uns;
         m1_addr = t.addr; m1_wdata = t.wdata;
      end
   endtask

   function automatic logic port_gnt(input int p);   return (p == 0) ? m0_gnt : m1_gnt;     endfunction
   function automatic logic port_ready(input int p); return (p == 0) ? m0_ready : m1_ready; endfunction
   function automatic logic port_err(input int p);   return (p == 0) ? m0_err : m1_err;     endfunction
   function automatic logic [31:0] port_rdata(input int p); return (p == 0) ? m0_rdata : m1_rdata; endfunction
   function automatic int qsize(input int p); return (p == 0) ? q0.size() : q1.size(); endfunction

   function automatic txn_t mk(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
      txn_t t;
      t.we = we; t.size = size; t.uns = uns; t.addr = addr; t.wdata = wdata;
      return t;
   endfunction

   function automatic txn_t rand_txn();
      txn_t t;
      int   r;
      t.we = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 15);
      t.size  = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
      t.uns   = 1'($urandom_range(0, 1));
      t.addr  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(1016, 1040))
                                            : 32'($urandom_range(0, 63));
      t.wdata = $urandom;
      return t;
   endfunction

   // driver: runs every queued transaction of port p, back to back
   task automatic drive_port(input int p, input bit spacing);
      txn_t        t;
      int          g, r, k, ce0, wr0, prev_r, e_lat, e_ce, e_wr;
      logic [32:0] e;
      bit          first;
      first  = 1;
      prev_r = 0;
      t      = '0;
      while (qsize(p) > 0) begin
         t = (p == 0) ? q0.pop_front() : q1.pop_front();
         set_port(p, 1'b1, t);
         #1;
         k = 0;
         while (!port_gnt(p) && k < 200) begin
            @(negedge clk); #1; k++;
         end
         if (!port_gnt(p)) begin
            check("gnt_timeout", 32'h0, 32'h1);
            set_port(p, 1'b0, t);
            return;
         end
         g   = cyc;
         ce0 = ce_cnt;
         wr0 = wr_cnt;
         gnt_order.push_back(p);
         exp_q.push_back(model_exec(t));
         k = 0;
         do begin
            @(negedge clk); #1; k++;
         end while (!port_ready(p) && k < 10);
         if (!port_ready(p)) begin
            check("ready_timeout", 32'h0, 32'h1);
            set_port(p, 1'b0, t);
            return;
         end
         r = cyc;
         e = exp_q.pop_front();
         if (e[32]) begin
            e_lat = 1; e_ce = 0; e_wr = 0;
         end else if (t.we && t.size != 2'b10) begin
            e_lat = 3; e_ce = 2; e_wr = 1;
         end else begin
            e_lat = 2; e_ce = 1; e_wr = t.we ? 1 : 0;
         end
         check("latency", 32'(r - g), 32'(e_lat));
         check("err", {31'b0, port_err(p)}, {31'b0, e[32]});
         if (!e[32]) check("rdata", port_rdata(p), e[31:0]);
         check("ce_cycles", 32'(ce_cnt - ce0), 32'(e_ce));
         check("we_cycles", 32'(wr_cnt - wr0), 32'(e_wr));
         if (spacing && !first) check("ready_spacing", 32'(r - prev_r), 32'd6);
         first         = 0;
         prev_r        = r;
         last_rdata[p] = port_rdata(p);
         last_err[p]   = port_err(p);
      end
      set_port(p, 1'b0, t);
   endtask

   // main sequence
   initial begin
      txn_t t;
      int   wr0;
      bit   saw_ready;

      // reset with a pending request: nothing may be granted
      set_port(0, 1'b1, mk(0, 2'b10, 0, 32'h0, 32'h0));
      for (int i = 0; i < 256; i++) preload(i, $urandom);
      @(negedge clk); #1;
      check("rst_m0_gnt", {31'b0, m0_gnt}, 32'h0);
      check("rst_m1_gnt", {31'b0, m1_gnt}, 32'h0);
      check("rst_m0_ready", {31'b0, m0_ready}, 32'h0);
      check("rst_m1_ready", {31'b0, m1_ready}, 32'h0);
      check("rst_m0_err", {31'b0, m0_err}, 32'h0);
      check("rst_m1_err", {31'b0, m1_err}, 32'h0);
      check("rst_m0_rdata", m0_rdata, 32'h0);
      check("rst_m1_rdata", m1_rdata, 32'h0);
      check("rst_mem_we", {31'b0, mem_we}, 32'h0);
      set_port(0, 1'b0, mk(0, 2'b10, 0, 32'h0, 32'h0));
      @(negedge clk);
      rst = 1'b0;

      // both ports load continuously from reset: strict alternation, m0 first
      gnt_order.delete();
      for (int i = 0; i < 4; i++) begin
         q0.push_back(mk(0, 2'b10, 0, 32'($urandom_range(0, 255) * 4), 32'h0));
         q1.push_back(mk(0, 2'b10, 0, 32'($urandom_range(0, 255) * 4), 32'h0));
      end
      fork
         drive_port(0, 1'b1);
         drive_port(1, 1'b1);
      join
      check("rr_count", 32'(gnt_order.size()), 32'd8);
      for (int i = 0; i < gnt_order.size(); i++) check("rr_order", 32'(gnt_order[i]), 32'(i % 2));

      // sub-word loads from 0x8899AABB
      preload(4, 32'h8899AABB);
      @(negedge clk);
      q0.push_back(mk(0, 2'b00, 0, 32'h12, 32'h0));
      drive_port(0, 1'b0);
      check("ld_byte_signed", last_rdata[0], 32'hFFFFFF99);
      q0.push_back(mk(0, 2'b00, 1, 32'h12, 32'h0));
      drive_port(0, 1'b0);
      check("ld_byte_unsigned", last_rdata[0], 32'h00000099);

      // half store read-modify-write
      q0.push_back(mk(1, 2'b01, 0, 32'h12, 32'h00001234));
      drive_port(0, 1'b0);
      check("rmw_waddr", last_waddr, 32'h10);
      check("rmw_wdata", last_wdata, 32'h1234AABB);
      q0.push_back(mk(0, 2'b10, 0, 32'h10, 32'h0));
      drive_port(0, 1'b0);
      check("rmw_readback", last_rdata[0], 32'h1234AABB);

      // port 1 word store, port 0 readback
      q1.push_back(mk(1, 2'b10, 0, 32'h0C, 32'hDEADBEEF));
      drive_port(1, 1'b0);
      check("m1_store_addr", last_waddr, 32'h0C);
      q0.push_back(mk(0, 2'b10, 0, 32'h0C, 32'h0));
      drive_port(0, 1'b0);
      check("m1_store_readback", last_rdata[0], 32'hDEADBEEF);

      // error cases
      q0.push_back(mk(0, 2'b10, 0, 32'(DEPTH_BYTES), 32'h0));
      drive_port(0, 1'b0);
      check("oor_err", {31'b0, last_err[0]}, 32'h1);
      q1.push_back(mk(0, 2'b11, 0, 32'h4, 32'h0));
      drive_port(1, 1'b0);
      check("size11_err", {31'b0, last_err[1]}, 32'h1);
      q0.push_back(mk(0, 2'b01, 1, 32'h11, 32'h0));
      drive_port(0, 1'b0);
`ifdef DMEM_MISALIGN_CHECK_EN
      check("misalign_err", {31'b0, last_err[0]}, 32'h1);
`else
      check("misalign_err", {31'b0, last_err[0]}, 32'h0);
      check("misalign_data", last_rdata[0], 32'h0000AABB);
`endif

      // reset during the RD cycle of a half store aborts it
      preload(8, 32'h11223344);
      @(negedge clk);
      t = mk(1, 2'b01, 0, 32'h22, 32'h0000BEEF);
      set_port(0, 1'b1, t);
      #1 check("abort_gnt", {31'b0, m0_gnt}, 32'h1);
      wr0 = wr_cnt;
      saw_ready = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      set_port(0, 1'b0, t);
      #1 if (m0_ready) saw_ready = 1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) begin
         @(negedge clk); #1;
         if (m0_ready) saw_ready = 1;
      end
      check("abort_no_ready", {31'b0, saw_ready}, 32'h0);
      check("abort_no_write", 32'(wr_cnt - wr0), 32'h0);
      check("abort_mem", mem_arr[8], 32'h11223344);
      @(negedge clk);
      q0.push_back(mk(0, 2'b10, 0, 32'h20, 32'h0));
      drive_port(0, 1'b0);
      check("abort_after", last_rdata[0], 32'h11223344);

      // randomized traffic on both ports
      for (int i = 0; i < 40; i++) begin
         q0.push_back(rand_txn());
         q1.push_back(rand_txn());
      end
      @(negedge clk);
      fork
         drive_port(0, 1'b0);
         drive_port(1, 1'b0);
      join

      // final memory image against the model
      repeat (2) @(negedge clk);
      for (int i = 0; i < 256; i++)
         check("mem_image", mem_arr[i],
               {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
